// File: rtl/arb_mux_reg_pkg.sv
// Shared constants and helpers for the arbitrating register mux.
// Arbitration mode encodings and a constant-foldable clog2.
package arb_mux_reg_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_reg_if.sv
// Request/response bundle between the requesters and the arbitrating mux.
// The master side drives requests and out_ready; the slave side is the mux.
interface arb_mux_reg_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_lock;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_sel;
    logic               locked;

    modport master (
        output in_data, in_valid, in_lock, out_ready,
        input  in_ready, out_data, out_valid, out_sel, locked
    );

    modport slave (
        input  in_data, in_valid, in_lock, out_ready,
        output in_ready, out_data, out_valid, out_sel, locked
    );

endinterface

// File: rtl/arb_mux_reg_pick.sv
// Combinational winner search: first set candidate at or after ptr, modulo N.
// The candidate vector is doubled so the wrap becomes a plain rotate.
module arb_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     cand,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SEL_W:0] sum;

    assign dbl = {cand, cand};
    assign rot = N'(dbl >> ptr);
    assign any = |cand;

    always_comb begin
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) sum = {1'b0, ptr} + (SEL_W+1)'(k);
        end
        if (sum >= (SEL_W+1)'(N)) sum = sum - (SEL_W+1)'(N);
        win = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating mux with a registered valid/ready output stage.
// Holds lock and round-robin state; winner search lives in arb_pick.
module arb_mux_reg
    import arb_mux_reg_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N       = 4,
    parameter int SEL_W   = 2,
    parameter int RR_MODE = ARB_FIXED
) (
    input logic         clk,
    input logic         rst_n,
    arb_mux_reg_if.slave bus
);

    if (SEL_W != clog2(N) || N < 2 || N > 16) begin : g_bad_param
        $error("arb_mux_reg: SEL_W must equal clog2(N), N in 2..16");
    end

    logic [WIDTH-1:0] ch_data [N];
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] win;
    logic [N-1:0]     cand;
    logic [N-1:0]     ready;
    logic             valid_q;
    logic             locked_q;
    logic             any;
    logic             can_load;
    logic             xfer;

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // Held in reset, nothing is offered a grant.
    assign can_load = rst_n && (!valid_q || bus.out_ready);

    always_comb begin
        cand = bus.in_valid;
        if (locked_q) cand = bus.in_valid & (N'(1) << lock_ch);
    end

    assign pick_ptr = (RR_MODE == ARB_RR) ? rr_ptr : '0;

    arb_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .cand (cand),
        .ptr  (pick_ptr),
        .win  (win),
        .any  (any)
    );

    assign xfer    = any && can_load;
    assign ready   = xfer ? (N'(1) << win) : '0;
    assign rr_next = (win == SEL_W'(N - 1)) ? '0 : win + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            lock_ch  <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            data_q   <= ch_data[win];
            sel_q    <= win;
            valid_q  <= 1'b1;
            locked_q <= bus.in_lock[win];
            lock_ch  <= win;
            if (!bus.in_lock[win] && RR_MODE == ARB_RR) rr_ptr <= rr_next;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.locked    = locked_q;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(ready));

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: fixed-priority and round-robin instances
// share one stimulus; table rows plus hand sequences for multi-cycle cases.
module tb_arb_mux_reg;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   valid = 4'b1111;
    logic [3:0]   lock = 4'b0000;
    logic         oready = 1'b1;
    logic [127:0] data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arb_mux_reg_if #(.WIDTH(32), .N(4), .SEL_W(2)) f_bus ();
    arb_mux_reg_if #(.WIDTH(32), .N(4), .SEL_W(2)) r_bus ();

    assign f_bus.in_data   = data;
    assign f_bus.in_valid  = valid;
    assign f_bus.in_lock   = lock;
    assign f_bus.out_ready = oready;
    assign r_bus.in_data   = data;
    assign r_bus.in_valid  = valid;
    assign r_bus.in_lock   = lock;
    assign r_bus.out_ready = oready;

    arb_mux_reg #(.WIDTH(32), .N(4), .SEL_W(2), .RR_MODE(0)) f_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f_bus.slave)
    );

    arb_mux_reg #(.WIDTH(32), .N(4), .SEL_W(2), .RR_MODE(1)) r_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (r_bus.slave)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [3:0]  r_ready;
        logic [3:0]  f_ready;
        logic [1:0]  sel;
        logic [31:0] dout;
        logic        lk;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 4'b0000;
        lock  = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) data[i*32 +: 32] = 32'h11 * i;

        tbl[0] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 2'd0, 32'h00, 1'b0};
        tbl[1] = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0001, 2'd1, 32'h11, 1'b0};
        tbl[2] = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0001, 2'd2, 32'h22, 1'b0};
        tbl[3] = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0001, 2'd3, 32'h33, 1'b0};
        tbl[4] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 2'd0, 32'h00, 1'b0};
        tbl[5] = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 32'h11, 1'b0};
        tbl[6] = '{1'b0, 4'b0111, 4'b0100, 4'b0100, 4'b0001, 2'd2, 32'h22, 1'b1};
        tbl[7] = '{1'b0, 4'b0111, 4'b0100, 4'b0100, 4'b0001, 2'd2, 32'h22, 1'b1};
        tbl[8] = '{1'b0, 4'b0111, 4'b0000, 4'b0100, 4'b0001, 2'd2, 32'h22, 1'b0};
        tbl[9] = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 2'd0, 32'h00, 1'b0};

        // reset held with every channel requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(f_bus.out_valid), 32'd0);
        chk("rst_f_ready", 32'(f_bus.in_ready), 32'd0);
        chk("rst_r_ready", 32'(r_bus.in_ready), 32'd0);
        chk("rst_locked", 32'(f_bus.locked), 32'd0);
        chk("rst_out_data", f_bus.out_data, 32'd0);
        chk("rst_out_sel", 32'(f_bus.out_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_f_ready", 32'(f_bus.in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("first_out_valid", 32'(f_bus.out_valid), 32'd1);
        chk("first_out_sel", 32'(f_bus.out_sel), 32'd0);

        // round-robin rotation, lock hold and release, wrap
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            @(negedge clk);
            valid = tbl[i].valid;
            lock  = tbl[i].lock;
            #1;
            chk($sformatf("row%0d_r_ready", i), 32'(r_bus.in_ready),
                32'(tbl[i].r_ready));
            chk($sformatf("row%0d_f_ready", i), 32'(f_bus.in_ready),
                32'(tbl[i].f_ready));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_sel", i), 32'(r_bus.out_sel),
                32'(tbl[i].sel));
            chk($sformatf("row%0d_data", i), r_bus.out_data, tbl[i].dout);
            chk($sformatf("row%0d_valid", i), 32'(r_bus.out_valid), 32'd1);
            chk($sformatf("row%0d_locked", i), 32'(r_bus.locked),
                32'(tbl[i].lk));
        end

        // backpressure: held word stays put, release loads without a bubble
        do_reset();
        @(negedge clk);
        valid = 4'b0100;
        lock  = 4'b0000;
        data[64 +: 32] = 32'hDEADBEEF;
        #1;
        chk("bp_load_ready", 32'(f_bus.in_ready), 32'b0100);
        @(posedge clk);
        #1;
        chk("bp_load_data", f_bus.out_data, 32'hDEADBEEF);
        chk("bp_load_sel", 32'(f_bus.out_sel), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                oready = 1'b0;
                data[64 +: 32] = 32'hCAFEF00D;
            end
            #1;
            chk($sformatf("bp%0d_ready", i), 32'(f_bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_data", i), f_bus.out_data, 32'hDEADBEEF);
            chk($sformatf("bp%0d_sel", i), 32'(f_bus.out_sel), 32'd2);
            chk($sformatf("bp%0d_valid", i), 32'(f_bus.out_valid), 32'd1);
        end
        @(negedge clk);
        oready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(f_bus.in_ready), 32'b0100);
        @(posedge clk);
        #1;
        chk("bp_rel_data", f_bus.out_data, 32'hCAFEF00D);
        chk("bp_rel_valid", 32'(f_bus.out_valid), 32'd1);

        // locked on ch1 while ch1 goes idle: nobody else is served
        do_reset();
        @(negedge clk);
        valid = 4'b0010;
        lock  = 4'b0010;
        #1;
        chk("stall_lock_ready", 32'(r_bus.in_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("stall_lock_locked", 32'(r_bus.locked), 32'd1);
        chk("stall_lock_sel", 32'(r_bus.out_sel), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid = 4'b1101;
            lock  = 4'b0000;
            #1;
            chk($sformatf("stall%0d_r_ready", i), 32'(r_bus.in_ready), 32'd0);
            chk($sformatf("stall%0d_f_ready", i), 32'(f_bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", i), 32'(r_bus.out_valid), 32'd0);
            chk($sformatf("stall%0d_locked", i), 32'(r_bus.locked), 32'd1);
        end

        // asynchronous reset in the middle of a locked, full stage
        do_reset();
        @(negedge clk);
        valid = 4'b0001;
        lock  = 4'b0000;
        @(negedge clk);
        valid = 4'b0010;
        lock  = 4'b0010;
        @(posedge clk);
        #1;
        chk("ar_pre_valid", 32'(r_bus.out_valid), 32'd1);
        chk("ar_pre_locked", 32'(r_bus.locked), 32'd1);
        chk("ar_pre_ptr", 32'(r_dut.rr_ptr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(r_bus.out_valid), 32'd0);
        chk("ar_locked", 32'(r_bus.locked), 32'd0);
        chk("ar_ptr", 32'(r_dut.rr_ptr), 32'd0);
        chk("ar_data", r_bus.out_data, 32'd0);
        chk("ar_ready", 32'(r_bus.in_ready), 32'd0);
        chk("ar_f_valid", 32'(f_bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
